// File: rtl/pipe_pkg.sv
// Shared pipeline-control constants: hazard FSM state encoding, operand
// forward-select codes and the bit positions inside the stall/flush vectors.
package pipe_pkg;

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_IMISS    = 2'd1;
   localparam logic [1:0] ST_DMISS    = 2'd2;
   localparam logic [1:0] ST_REDIRECT = 2'd3;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   // stall is {M,E,D,F}, flush is {W,M,E,D}, both LSB-first
   localparam int STALL_F = 0;
   localparam int STALL_D = 1;
   localparam int STALL_E = 2;
   localparam int STALL_M = 3;

   localparam int FLUSH_D = 0;
   localparam int FLUSH_E = 1;
   localparam int FLUSH_M = 2;
   localparam int FLUSH_W = 3;

endpackage

// File: rtl/fwd_sel.sv
// Operand forward select for one E-stage source: M has priority over W,
// and x0 never forwards.
module fwd_sel
   import pipe_pkg::*;
#(
   parameter int REGW = 5
) (
   input  logic [REGW-1:0] rsE,
   input  logic [REGW-1:0] rdM,
   input  logic [REGW-1:0] rdW,
   input  logic            RegWriteM,
   input  logic            RegWriteW,
   output logic [1:0]      sel
);

   always_comb begin
      sel = FWD_RF;
      if (RegWriteM && (rdM != '0) && (rdM == rsE)) begin
         sel = FWD_M;
      end else if (RegWriteW && (rdW != '0) && (rdW == rsE)) begin
         sel = FWD_W;
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: miss/redirect FSM producing stall and flush
// enables, combinational operand forwarding and saturating miss counters.
module hazard_unit
   import pipe_pkg::*;
#(
   parameter int REGW = 5,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            ihit,
   input  logic            dhit,
   input  logic            MemAccessM,
   input  logic            LoadE,
   input  logic            BranchTakenM,
   input  logic            RegWriteM,
   input  logic            RegWriteW,
   input  logic [REGW-1:0] rs1D,
   input  logic [REGW-1:0] rs2D,
   input  logic [REGW-1:0] rs1E,
   input  logic [REGW-1:0] rs2E,
   input  logic [REGW-1:0] rdE,
   input  logic [REGW-1:0] rdM,
   input  logic [REGW-1:0] rdW,
   output logic [3:0]      stall,
   output logic [3:0]      flush,
   output logic            sendNop,
   output logic [1:0]      forwardAE,
   output logic [1:0]      forwardBE,
   output logic [CNTW-1:0] istall_cnt,
   output logic [CNTW-1:0] dstall_cnt
);

   logic [1:0]      state_q, state_d;
   logic [CNTW-1:0] istall_q, dstall_q;
   logic [3:0]      stallRaw, flushRaw;
   logic            dMiss, loadUse;

   assign dMiss   = MemAccessM & ~dhit;
   assign loadUse = LoadE & (rdE != '0) & ((rdE == rs1D) | (rdE == rs2D));

   always_comb begin
      state_d  = state_q;
      stallRaw = 4'b0000;
      flushRaw = 4'b0000;
      if (dMiss) begin
         stallRaw = 4'b1111;
         flushRaw[FLUSH_W] = 1'b1;
         state_d = ST_DMISS;
      end else if (BranchTakenM) begin
         // a pending I-miss belongs to the wrong path and is dropped
         flushRaw[FLUSH_D] = 1'b1;
         flushRaw[FLUSH_E] = 1'b1;
         flushRaw[FLUSH_M] = 1'b1;
         state_d = ST_REDIRECT;
      end else if (state_q == ST_REDIRECT) begin
         if (!ihit) begin
            flushRaw[FLUSH_D] = 1'b1;
            state_d = ST_IMISS;
         end else begin
            state_d = ST_RUN;
         end
      end else if (!ihit) begin
         stallRaw[STALL_F] = 1'b1;
         flushRaw[FLUSH_D] = 1'b1;
         state_d = ST_IMISS;
      end else begin
         state_d = ST_RUN;
         if (loadUse) begin
            stallRaw[STALL_F] = 1'b1;
            stallRaw[STALL_D] = 1'b1;
            flushRaw[FLUSH_E] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_RUN;
         istall_q <= '0;
         dstall_q <= '0;
      end else begin
         state_q <= state_d;
         if ((state_q == ST_IMISS) && (istall_q != '1)) begin
            istall_q <= istall_q + CNTW'(1);
         end
         if ((state_q == ST_DMISS) && (dstall_q != '1)) begin
            dstall_q <= dstall_q + CNTW'(1);
         end
      end
   end

   // control outputs are gated so an asserted reset silences them without a clock
   assign stall      = reset ? stallRaw : 4'b0000;
   assign flush      = reset ? flushRaw : 4'b0000;
   assign sendNop    = flush[FLUSH_E];
   assign istall_cnt = istall_q;
   assign dstall_cnt = dstall_q;

   fwd_sel #(.REGW(REGW)) u_fwdA (
      .rsE       (rs1E),
      .rdM       (rdM),
      .rdW       (rdW),
      .RegWriteM (RegWriteM),
      .RegWriteW (RegWriteW),
      .sel       (forwardAE)
   );

   fwd_sel #(.REGW(REGW)) u_fwdB (
      .rsE       (rs2E),
      .rdM       (rdM),
      .rdW       (rdW),
      .RegWriteM (RegWriteM),
      .RegWriteW (RegWriteW),
      .sel       (forwardBE)
   );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a default-width instance and a CNTW=2
// instance share all stimulus so counter saturation is visible.
module tb_hazard_unit;

   logic       clk, reset;
   logic       ihit, dhit, MemAccessM, LoadE, BranchTakenM, RegWriteM, RegWriteW;
   logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;

   logic [3:0]  stall, flush, stallS, flushS;
   logic        sendNop, sendNopS;
   logic [1:0]  forwardAE, forwardBE, forwardAES, forwardBES;
   logic [15:0] istall_cnt, dstall_cnt;
   logic [1:0]  istallS, dstallS;

   int checkCount = 0;
   int passCount  = 0;

   hazard_unit dut (
      .clk(clk), .reset(reset), .ihit(ihit), .dhit(dhit), .MemAccessM(MemAccessM),
      .LoadE(LoadE), .BranchTakenM(BranchTakenM), .RegWriteM(RegWriteM),
      .RegWriteW(RegWriteW), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
      .rdE(rdE), .rdM(rdM), .rdW(rdW), .stall(stall), .flush(flush),
      .sendNop(sendNop), .forwardAE(forwardAE), .forwardBE(forwardBE),
      .istall_cnt(istall_cnt), .dstall_cnt(dstall_cnt)
   );

   hazard_unit #(.REGW(5), .CNTW(2)) dutSmall (
      .clk(clk), .reset(reset), .ihit(ihit), .dhit(dhit), .MemAccessM(MemAccessM),
      .LoadE(LoadE), .BranchTakenM(BranchTakenM), .RegWriteM(RegWriteM),
      .RegWriteW(RegWriteW), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
      .rdE(rdE), .rdM(rdM), .rdW(rdW), .stall(stallS), .flush(flushS),
      .sendNop(sendNopS), .forwardAE(forwardAES), .forwardBE(forwardBES),
      .istall_cnt(istallS), .dstall_cnt(dstallS)
   );

   // free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // safety net so a broken design can never hang the run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic setIdle();
      ihit = 1'b1; dhit = 1'b1; MemAccessM = 1'b0; LoadE = 1'b0;
      BranchTakenM = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
      rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0; rdE = '0; rdM = '0; rdW = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      setIdle();
      reset = 1'b0;
      step();
      reset = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      setIdle();
      reset = 1'b0;
      MemAccessM = 1'b1; dhit = 1'b0; BranchTakenM = 1'b1;
      #2;
      checkCount++; if (stall !== 4'b0000) $display("[TB] FAIL rst_stall: got %b expected 0000", stall); else passCount++;
      checkCount++; if (flush !== 4'b0000) $display("[TB] FAIL rst_flush: got %b expected 0000", flush); else passCount++;
      checkCount++; if (sendNop !== 1'b0) $display("[TB] FAIL rst_sendNop: got %b expected 0", sendNop); else passCount++;
      step();
      checkCount++; if (istall_cnt !== 16'd0 || dstall_cnt !== 16'd0) $display("[TB] FAIL rst_cnt: got %0d/%0d expected 0/0", istall_cnt, dstall_cnt); else passCount++;
      setIdle();
      reset = 1'b1;
      #1;
      checkCount++; if (stall !== 4'b0000 || flush !== 4'b0000) $display("[TB] FAIL idle: got %b/%b expected 0000/0000", stall, flush); else passCount++;
   endtask

   task automatic test_load_use();
      doReset();
      LoadE = 1'b1; rdE = 5'd5; rs1D = 5'd5; rs2D = 5'd3;
      #1;
      checkCount++; if (stall !== 4'b0011) $display("[TB] FAIL lu_stall: got %b expected 0011", stall); else passCount++;
      checkCount++; if (flush !== 4'b0010) $display("[TB] FAIL lu_flush: got %b expected 0010", flush); else passCount++;
      checkCount++; if (sendNop !== 1'b1) $display("[TB] FAIL lu_sendNop: got %b expected 1", sendNop); else passCount++;
      step();
      // the load has moved on to M
      LoadE = 1'b0; rdE = 5'd0;
      #1;
      checkCount++; if (stall !== 4'b0000 || sendNop !== 1'b0) $display("[TB] FAIL lu_release: got %b/%b expected 0000/0", stall, sendNop); else passCount++;
      LoadE = 1'b1; rdE = 5'd9; rs1D = 5'd1; rs2D = 5'd9;
      #1;
      checkCount++; if (stall !== 4'b0011) $display("[TB] FAIL lu_rs2: got %b expected 0011", stall); else passCount++;
      rdE = 5'd0; rs1D = 5'd0; rs2D = 5'd0;
      #1;
      checkCount++; if (stall !== 4'b0000 || flush !== 4'b0000) $display("[TB] FAIL lu_x0: got %b/%b expected 0000/0000", stall, flush); else passCount++;
      rdE = 5'd4; rs1D = 5'd2; rs2D = 5'd3;
      #1;
      checkCount++; if (stall !== 4'b0000) $display("[TB] FAIL lu_nomatch: got %b expected 0000", stall); else passCount++;
   endtask

   task automatic test_dmiss();
      doReset();
      MemAccessM = 1'b1; dhit = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checkCount++; if (stall !== 4'b1111 || flush !== 4'b1000) $display("[TB] FAIL dm_cyc%0d: got %b/%b expected 1111/1000", i, stall, flush); else passCount++;
         step();
      end
      dhit = 1'b1;
      #1;
      checkCount++; if (stall !== 4'b0000 || flush !== 4'b0000) $display("[TB] FAIL dm_done: got %b/%b expected 0000/0000", stall, flush); else passCount++;
      step();
      checkCount++; if (dstall_cnt !== 16'd3) $display("[TB] FAIL dm_cnt: got %0d expected 3", dstall_cnt); else passCount++;
      MemAccessM = 1'b0;
      step();
      checkCount++; if (dstall_cnt !== 16'd3 || stall !== 4'b0000) $display("[TB] FAIL dm_run: got %0d/%b expected 3/0000", dstall_cnt, stall); else passCount++;
      // D-miss outranks a taken branch and an I-miss
      MemAccessM = 1'b1; dhit = 1'b0; BranchTakenM = 1'b1; ihit = 1'b0;
      #1;
      checkCount++; if (stall !== 4'b1111 || flush !== 4'b1000) $display("[TB] FAIL dm_prio: got %b/%b expected 1111/1000", stall, flush); else passCount++;
   endtask

   task automatic test_branch_imiss();
      doReset();
      BranchTakenM = 1'b1; ihit = 1'b0;
      #1;
      checkCount++; if (flush !== 4'b0111 || stall !== 4'b0000) $display("[TB] FAIL br_take: got %b/%b expected 0111/0000", flush, stall); else passCount++;
      checkCount++; if (sendNop !== 1'b1) $display("[TB] FAIL br_sendNop: got %b expected 1", sendNop); else passCount++;
      step();
      BranchTakenM = 1'b0;
      #1;
      checkCount++; if (flush !== 4'b0001 || stall !== 4'b0000) $display("[TB] FAIL br_redirect: got %b/%b expected 0001/0000", flush, stall); else passCount++;
      step();
      checkCount++; if (stall !== 4'b0001 || flush !== 4'b0001) $display("[TB] FAIL im_wait: got %b/%b expected 0001/0001", stall, flush); else passCount++;
      step();
      ihit = 1'b1;
      #1;
      checkCount++; if (stall !== 4'b0000 || flush !== 4'b0000) $display("[TB] FAIL im_done: got %b/%b expected 0000/0000", stall, flush); else passCount++;
      step();
      checkCount++; if (istall_cnt !== 16'd2) $display("[TB] FAIL im_cnt: got %0d expected 2", istall_cnt); else passCount++;
      step();
      checkCount++; if (istall_cnt !== 16'd2) $display("[TB] FAIL im_run: got %0d expected 2", istall_cnt); else passCount++;
      // redirect with the new target already in the cache goes straight back
      BranchTakenM = 1'b1;
      step();
      BranchTakenM = 1'b0;
      #1;
      checkCount++; if (flush !== 4'b0000 || stall !== 4'b0000) $display("[TB] FAIL br_hit: got %b/%b expected 0000/0000", flush, stall); else passCount++;
      step();
      step();
      checkCount++; if (istall_cnt !== 16'd2) $display("[TB] FAIL br_hit_cnt: got %0d expected 2", istall_cnt); else passCount++;
   endtask

   task automatic test_forwarding();
      doReset();
      rs1E = 5'd7; rdM = 5'd7; rdW = 5'd7; RegWriteM = 1'b1; RegWriteW = 1'b1;
      rs2E = 5'd0;
      #1;
      checkCount++; if (forwardAE !== 2'b10) $display("[TB] FAIL fw_m: got %b expected 10", forwardAE); else passCount++;
      checkCount++; if (forwardBE !== 2'b00) $display("[TB] FAIL fw_b_x0: got %b expected 00", forwardBE); else passCount++;
      RegWriteM = 1'b0;
      #1;
      checkCount++; if (forwardAE !== 2'b01) $display("[TB] FAIL fw_w: got %b expected 01", forwardAE); else passCount++;
      RegWriteW = 1'b0;
      #1;
      checkCount++; if (forwardAE !== 2'b00) $display("[TB] FAIL fw_rf: got %b expected 00", forwardAE); else passCount++;
      RegWriteM = 1'b1; RegWriteW = 1'b1; rs2E = 5'd7; rdW = 5'd3; rs1E = 5'd3;
      #1;
      checkCount++; if (forwardBE !== 2'b10 || forwardAE !== 2'b01) $display("[TB] FAIL fw_split: got %b/%b expected 10/01", forwardBE, forwardAE); else passCount++;
      rs1E = 5'd0; rdM = 5'd0; rdW = 5'd0;
      #1;
      checkCount++; if (forwardAE !== 2'b00) $display("[TB] FAIL fw_x0: got %b expected 00", forwardAE); else passCount++;
      // forwarding must stay live while the pipeline is frozen by a miss
      rs1E = 5'd12; rdM = 5'd12; MemAccessM = 1'b1; dhit = 1'b0;
      step();
      checkCount++; if (forwardAE !== 2'b10 || stall !== 4'b1111) $display("[TB] FAIL fw_stall: got %b/%b expected 10/1111", forwardAE, stall); else passCount++;
   endtask

   task automatic test_reset_mid_dmiss();
      doReset();
      MemAccessM = 1'b1; dhit = 1'b0;
      step();
      step();
      #2;
      reset = 1'b0;
      #1;
      checkCount++; if (stall !== 4'b0000 || flush !== 4'b0000 || sendNop !== 1'b0) $display("[TB] FAIL rm_out: got %b/%b/%b expected 0000/0000/0", stall, flush, sendNop); else passCount++;
      checkCount++; if (dstall_cnt !== 16'd0 || istall_cnt !== 16'd0) $display("[TB] FAIL rm_cnt: got %0d/%0d expected 0/0", dstall_cnt, istall_cnt); else passCount++;
      setIdle();
      step();
      reset = 1'b1;
      step();
      checkCount++; if (stall !== 4'b0000 || dstall_cnt !== 16'd0) $display("[TB] FAIL rm_fresh: got %b/%0d expected 0000/0", stall, dstall_cnt); else passCount++;
      // six miss cycles: DMISS is occupied at five edges
      MemAccessM = 1'b1; dhit = 1'b0;
      for (int i = 0; i < 6; i++) step();
      checkCount++; if (dstallS !== 2'd3) $display("[TB] FAIL sat_small: got %0d expected 3", dstallS); else passCount++;
      checkCount++; if (dstall_cnt !== 16'd5) $display("[TB] FAIL sat_wide: got %0d expected 5", dstall_cnt); else passCount++;
      step();
      checkCount++; if (dstallS !== 2'd3) $display("[TB] FAIL sat_hold: got %0d expected 3", dstallS); else passCount++;
   endtask

   initial begin
      setIdle();
      reset = 1'b0;
      test_reset();
      test_load_use();
      test_dmiss();
      test_branch_imiss();
      test_forwarding();
      test_reset_mid_dmiss();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter REGW, default 5: register-address width.
REQ-002 SHALL have parameter CNTW, default 16: stall-counter width.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 ihit  input  1  instruction cache hit for current fetch.
REQ-006 dhit  input  1  data cache hit for access in M.
REQ-007 MemAccessM  input  1  load or store in M.
REQ-008 LoadE  input  1  load in E.
REQ-009 BranchTakenM  input  1  branch/jump resolved taken in M.
REQ-010 RegWriteM  input  1  M instruction writes rd.
REQ-011 RegWriteW  input  1  W instruction writes rd.
REQ-012 rs1D, rs2D  input  REGW each  D-stage sources (one port each).
REQ-013 rs1E, rs2E  input  REGW each  E-stage sources (one port each).
REQ-014 rdE, rdM, rdW  input  REGW each  destinations in E, M, W (one port each).
REQ-015 stall  output  4  {M,E,D,F} pipeline-register hold enables.
REQ-016 flush  output  4  {W,M,E,D} pipeline-register bubble inserts.
REQ-017 sendNop  output  1  zero the control word entering E; equals flush[1].
REQ-018 forwardAE, forwardBE  output  2 each  operand select: 00 regfile, 01 W, 10 M.
REQ-019 istall_cnt, dstall_cnt  output  CNTW each  cycles spent in IMISS / DMISS.

Function
REQ-020 FSM states SHALL be RUN, IMISS, DMISS, REDIRECT; outputs are functions of state and current inputs.
REQ-021 Event priority every cycle SHALL be: D-miss > taken branch > I-miss > load-use.
REQ-022 D-miss (MemAccessM & !dhit): stall=1111, flush=1000; enter/remain DMISS; the cycle dhit=1 in DMISS, stall=0000 and next state RUN.
REQ-023 Taken branch (no D-miss): flush=0111, stall=0000; next state REDIRECT; a concurrent I-miss SHALL be abandoned.
REQ-024 REDIRECT SHALL last one cycle; flush[0]=1 if !ihit then next IMISS, else RUN.
REQ-025 I-miss (!ihit, no higher event): stall=0001, flush=0001; enter/remain IMISS; the cycle ihit=1, stall=0000, flush=0000, next RUN.
REQ-026 Load-use (LoadE, rdE!=0, rdE==rs1D or rs2D, no higher event): stall=0011, flush=0010 for exactly one cycle, no state change.
REQ-027 forwardAE SHALL be 10 if RegWriteM & rdM!=0 & rdM==rs1E; else 01 if RegWriteW & rdW!=0 & rdW==rs1E; else 00; forwardBE identically on rs2E.
REQ-028 Forwarding SHALL be combinational and valid in every state, including stalls.
REQ-029 Register x0 SHALL never trigger forwarding or load-use.
REQ-030 istall_cnt increments each cycle state==IMISS, dstall_cnt each cycle state==DMISS; both saturate at all-ones, never wrap.
REQ-031 With no event, stall=0000, flush=0000, sendNop=0.

Reset
REQ-032 reset low SHALL immediately force state RUN, istall_cnt=0, dstall_cnt=0, stall=0000, flush=0000, sendNop=0 regardless of clk.
REQ-033 Reset asserted mid-miss SHALL abandon the miss; after release the block evaluates inputs fresh in RUN.

Structure
REQ-034 State encoding, forward-select codes (FWD_RF=00, FWD_W=01, FWD_M=10) and stall/flush bit positions SHALL live in shared package pipe_pkg.
REQ-035 Forwarding comparison SHALL be sub-module fwd_sel (inputs rsE, rdM, rdW, RegWriteM, RegWriteW; output 2-bit select), instantiated twice.

Verification
REQ-036 Load-use: LoadE=1, rdE=5, rs1D=5 -> one cycle stall=0011, flush=0010, sendNop=1; rdE=0 -> no stall.
REQ-037 D-miss: MemAccessM=1, dhit=0 for 3 cycles then 1 -> stall=1111 for 3 cycles, dstall_cnt=3, RUN after.
REQ-038 Branch with I-miss: BranchTakenM=1, ihit=0 -> flush=0111, REDIRECT, then IMISS; ihit=1 two cycles later -> RUN, istall_cnt=2.
REQ-039 Forwarding: rs1E=rdM=rdW=7, RegWriteM=RegWriteW=1 -> forwardAE=10; RegWriteM=0 -> 01; rs2E=0 -> forwardBE=00.
REQ-040 Reset mid-DMISS: reset low in cycle 2 of miss -> outputs zero immediately, counters 0; CNTW=2 bench saturates dstall_cnt at 3.
